// File: rtl/dcf77_pkg.sv
// ---------------------------------------------------------------------------
// dcf77_pkg : shared types, frame bit positions and timing for the DCF77 generator
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dcf77_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2,
      ST_MARK  = 2'd3
   } state_e;

   localparam int FRAME_BITS = 59;

   localparam int START_BIT  = 0;
   localparam int TIME_START = 20;
   localparam int MIN_PAR    = 28;
   localparam int HOUR_PAR   = 35;
   localparam int DATE_PAR   = 58;

   localparam int MIN_LO  = 21;
   localparam int MIN_HI  = 27;
   localparam int HOUR_LO = 29;
   localparam int HOUR_HI = 34;
   localparam int DATE_LO = 36;
   localparam int DATE_HI = 57;

   function automatic int cnt_sec(input int freq);
      return freq;
   endfunction

   function automatic int cnt_zero(input int freq);
      return freq / 10;
   endfunction

   function automatic int cnt_one(input int freq);
      return freq / 5;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dcf77_frame_fixup.sv
// ---------------------------------------------------------------------------
// dcf77_frame_fixup : forces start/time-start bits and fills in even parity
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcf77_frame_fixup
   import dcf77_pkg::*;
(
   input  logic [FRAME_BITS-1:0] frame_i,
   output logic [FRAME_BITS-1:0] frame_o
);

   always_comb begin
      frame_o             = frame_i;
      frame_o[START_BIT]  = 1'b0;
      frame_o[TIME_START] = 1'b1;
      frame_o[MIN_PAR]    = ^frame_i[MIN_HI:MIN_LO];
      frame_o[HOUR_PAR]   = ^frame_i[HOUR_HI:HOUR_LO];
      frame_o[DATE_PAR]   = ^frame_i[DATE_HI:DATE_LO];
   end

endmodule

`default_nettype wire

// File: rtl/dcf77_generator.sv
// ---------------------------------------------------------------------------
// dcf77_generator : DCF77 pulse-train generator with one-deep frame shadow buffer
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcf77_generator
   import dcf77_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 16000000,
   parameter int AUTO_PARITY     = 1
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [FRAME_BITS-1:0] frame_in,
   input  logic                  frame_valid,
   output logic                  frame_ready,
   output logic                  dcf77_non_inverted,
   output logic [5:0]            sec_index,
   output logic                  second_strobe,
   output logic                  minute_strobe,
   output logic                  underrun,
   output logic                  busy
);

   localparam int CNT_SEC = cnt_sec(CLOCK_FREQUENCY);
   localparam int CNT_W   = $clog2(CNT_SEC);

   localparam logic [CNT_W-1:0] SEC_END  = CNT_W'(CNT_SEC - 1);
   localparam logic [CNT_W-1:0] ZERO_END = CNT_W'(cnt_zero(CLOCK_FREQUENCY) - 1);
   localparam logic [CNT_W-1:0] ONE_END  = CNT_W'(cnt_one(CLOCK_FREQUENCY) - 1);
   localparam logic [5:0]       LAST_DATA_SEC = 6'(FRAME_BITS - 1);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [5:0]              sec_q, sec_d;
   logic [FRAME_BITS-1:0]   shadow_q, shadow_d;
   logic [FRAME_BITS-1:0]   active_q, active_d;
   logic                    shadow_full_q, shadow_full_d;
   logic                    frame_ready_q, dcf_q, dcf_d, busy_q, busy_d;
   logic                    sec_strobe_q, sec_strobe_d, min_strobe_q, min_strobe_d;
   logic                    underrun_q, underrun_d;

   logic                    load, miss, sec_start, min_start;
   logic [FRAME_BITS-1:0]   fixed;
   logic [63:0]             active_ext;
   logic                    cur_bit;
   logic [CNT_W-1:0]        pulse_end;

   generate
      if (AUTO_PARITY != 0) begin : g_fixup
         dcf77_frame_fixup u_fixup (
            .frame_i (shadow_q),
            .frame_o (fixed)
         );
      end else begin : g_bypass
         assign fixed = shadow_q;
      end
   endgenerate

   // Zero-extended so the index never leaves the vector while sec_q reads 59.
   assign active_ext = {5'd0, active_q};
   assign cur_bit    = active_ext[sec_q];
   assign pulse_end  = cur_bit ? ONE_END : ZERO_END;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         sec_q         <= '0;
         shadow_q      <= '0;
         active_q      <= '0;
         shadow_full_q <= 1'b0;
         frame_ready_q <= 1'b1;
         dcf_q         <= 1'b0;
         busy_q        <= 1'b0;
         sec_strobe_q  <= 1'b0;
         min_strobe_q  <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         sec_q         <= sec_d;
         shadow_q      <= shadow_d;
         active_q      <= active_d;
         shadow_full_q <= shadow_full_d;
         frame_ready_q <= !shadow_full_d;
         dcf_q         <= dcf_d;
         busy_q        <= busy_d;
         sec_strobe_q  <= sec_strobe_d;
         min_strobe_q  <= min_strobe_d;
         underrun_q    <= underrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sec_d     = sec_q;
      load      = 1'b0;
      miss      = 1'b0;
      sec_start = 1'b0;
      min_start = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         sec_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (shadow_full_q) begin
                  load      = 1'b1;
                  state_d   = ST_PULSE;
                  cnt_d     = '0;
                  sec_d     = '0;
                  sec_start = 1'b1;
                  min_start = 1'b1;
               end
            end
            ST_PULSE: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == pulse_end) state_d = ST_GAP;
            end
            ST_GAP: begin
               if (cnt_q == SEC_END) begin
                  cnt_d     = '0;
                  sec_d     = sec_q + 6'd1;
                  sec_start = 1'b1;
                  state_d   = (sec_q == LAST_DATA_SEC) ? ST_MARK : ST_PULSE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_MARK: begin
               if (cnt_q == SEC_END) begin
                  cnt_d     = '0;
                  sec_d     = '0;
                  sec_start = 1'b1;
                  min_start = 1'b1;
                  state_d   = ST_PULSE;
                  load      = shadow_full_q;
                  miss      = !shadow_full_q;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      dcf_d        = (state_d == ST_PULSE);
      busy_d       = (state_d != ST_IDLE);
      sec_strobe_d = sec_start;
      min_strobe_d = min_start;
      underrun_d   = miss;
   end

   // A load only happens with the shadow full, so it never coincides with an accept.
   always_comb begin
      shadow_d      = shadow_q;
      shadow_full_d = shadow_full_q;
      active_d      = active_q;
      if (load) begin
         active_d      = fixed;
         shadow_full_d = 1'b0;
      end else if (frame_valid && frame_ready_q) begin
         shadow_d      = frame_in;
         shadow_full_d = 1'b1;
      end
   end

   assign frame_ready        = frame_ready_q;
   assign dcf77_non_inverted = dcf_q;
   assign sec_index          = sec_q;
   assign second_strobe      = sec_strobe_q;
   assign minute_strobe      = min_strobe_q;
   assign underrun           = underrun_q;
   assign busy               = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dcf77_generator.sv
// ---------------------------------------------------------------------------
// tb_dcf77_generator : directed self-checking bench, 100 Hz clock scaling
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dcf77_generator;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [58:0] frame_in;
   logic        frame_valid;

   logic        frame_ready, dcf, second_strobe, minute_strobe, underrun, busy;
   logic [5:0]  sec_index;
   logic        ap_frame_ready, ap_dcf, ap_second_strobe, ap_minute_strobe, ap_underrun, ap_busy;
   logic [5:0]  ap_sec_index;

   int checks;
   int errors;

   int hi_cnt   [2][60];
   int first_lo [2][60];
   int idx_bad  [2][60];
   int strobe_bad, ur_cnt, busy_lo;

   logic [58:0] frame_b;

   dcf77_generator #(.CLOCK_FREQUENCY(100), .AUTO_PARITY(0)) dut (
      .clk                (clk),
      .reset              (reset),
      .enable             (enable),
      .frame_in           (frame_in),
      .frame_valid        (frame_valid),
      .frame_ready        (frame_ready),
      .dcf77_non_inverted (dcf),
      .sec_index          (sec_index),
      .second_strobe      (second_strobe),
      .minute_strobe      (minute_strobe),
      .underrun           (underrun),
      .busy               (busy)
   );

   dcf77_generator #(.CLOCK_FREQUENCY(100), .AUTO_PARITY(1)) dut_ap (
      .clk                (clk),
      .reset              (reset),
      .enable             (enable),
      .frame_in           (frame_in),
      .frame_valid        (frame_valid),
      .frame_ready        (ap_frame_ready),
      .dcf77_non_inverted (ap_dcf),
      .sec_index          (ap_sec_index),
      .second_strobe      (ap_second_strobe),
      .minute_strobe      (ap_minute_strobe),
      .underrun           (ap_underrun),
      .busy               (ap_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_width(input logic [58:0] f, input int s);
      if (s == 59) return 0;
      return f[s] ? 20 : 10;
   endfunction

   // Records one 6000-cycle minute of both instances, starting at second 0 phase 0.
   task automatic capture_minute();
      int s;
      int p;
      logic [1:0] dv;
      logic [5:0] ix [2];
      strobe_bad = 0;
      ur_cnt     = 0;
      busy_lo    = 0;
      for (int i = 0; i < 60; i++) begin
         for (int d = 0; d < 2; d++) begin
            hi_cnt[d][i]   = 0;
            first_lo[d][i] = 100;
            idx_bad[d][i]  = 0;
         end
      end
      for (int c = 0; c < 6000; c++) begin
         s = c / 100;
         p = c % 100;
         dv[0] = dcf;
         dv[1] = ap_dcf;
         ix[0] = sec_index;
         ix[1] = ap_sec_index;
         for (int d = 0; d < 2; d++) begin
            if (dv[d]) hi_cnt[d][s]++;
            else if (first_lo[d][s] == 100) first_lo[d][s] = p;
            if (ix[d] != 6'(s)) idx_bad[d][s]++;
         end
         if (second_strobe !== (p == 0)) strobe_bad++;
         if (minute_strobe !== (c == 0)) strobe_bad++;
         if (underrun) ur_cnt++;
         if (!busy) busy_lo++;
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b0; frame_valid = 1'b0; frame_in = '0;
      repeat (3) tick();
      checks++; if (dcf !== 1'b0) begin errors++; $display("FAIL reset_dcf: got %b expected 0", dcf); end
      checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", frame_ready); end
      checks++; if (sec_index !== 6'd0) begin errors++; $display("FAIL reset_sec: got %0d expected 0", sec_index); end
      checks++; if ({second_strobe, minute_strobe, underrun, busy} !== 4'b0) begin
         errors++; $display("FAIL reset_flags: got %b expected 0000", {second_strobe, minute_strobe, underrun, busy}); end
      checks++; if (ap_frame_ready !== 1'b1 || ap_dcf !== 1'b0) begin
         errors++; $display("FAIL reset_ap: got ready=%b dcf=%b expected 1/0", ap_frame_ready, ap_dcf); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_zero_frame();
      int w;
      int bad_idx;
      enable = 1'b1;
      tick(); tick();
      checks++; if (busy !== 1'b0 || dcf !== 1'b0) begin
         errors++; $display("FAIL idle_no_frame: got busy=%b dcf=%b expected 0/0", busy, dcf); end
      frame_in = '0; frame_valid = 1'b1;
      tick();
      checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL accept_ready: got %b expected 0", frame_ready); end
      frame_valid = 1'b0;
      tick();
      checks++; if ({minute_strobe, second_strobe, dcf, busy} !== 4'b1111 || sec_index !== 6'd0) begin
         errors++; $display("FAIL start_strobes: got ms/ss/dcf/busy=%b sec=%0d expected 1111 sec=0",
                            {minute_strobe, second_strobe, dcf, busy}, sec_index); end
      checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL start_ready: got %b expected 1", frame_ready); end
      capture_minute();
      bad_idx = 0;
      for (int s = 0; s < 60; s++) begin
         w = exp_width('0, s);
         bad_idx += idx_bad[0][s];
         checks++;
         if (hi_cnt[0][s] != w || first_lo[0][s] != w) begin
            errors++; $display("FAIL zero_width_s%0d: got high=%0d first_low=%0d expected %0d", s, hi_cnt[0][s], first_lo[0][s], w);
         end
      end
      checks++; if (bad_idx != 0) begin errors++; $display("FAIL zero_sec_index: got %0d bad cycles expected 0", bad_idx); end
      checks++; if (strobe_bad != 0) begin errors++; $display("FAIL zero_strobes: got %0d bad cycles expected 0", strobe_bad); end
      checks++; if (ur_cnt != 0 || busy_lo != 0) begin
         errors++; $display("FAIL zero_underrun_busy: got underrun=%0d idle=%0d expected 0/0", ur_cnt, busy_lo); end
      checks++; if (underrun !== 1'b1 || minute_strobe !== 1'b1 || dcf !== 1'b1) begin
         errors++; $display("FAIL next_minute_underrun: got ur=%b ms=%b dcf=%b expected 111", underrun, minute_strobe, dcf); end
   endtask

   task automatic test_queue();
      int   waited;
      bit   found;
      logic prev_ready;
      frame_b = '0;
      frame_b[5] = 1'b1; frame_b[21] = 1'b1; frame_b[22] = 1'b1; frame_b[23] = 1'b1;
      frame_in = frame_b; frame_valid = 1'b1;
      tick();
      checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL queue_ready_fall: got %b expected 0", frame_ready); end
      frame_valid = 1'b0;
      waited = 0; found = 1'b0; prev_ready = frame_ready;
      while (!found && waited < 6100) begin
         prev_ready = frame_ready;
         tick();
         waited++;
         if (minute_strobe === 1'b1) found = 1'b1;
      end
      checks++; if (!found || waited != 5999) begin
         errors++; $display("FAIL queue_load_time: got found=%0d after %0d cycles expected 5999", found, waited); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL queue_underrun: got %b expected 0", underrun); end
      checks++; if (prev_ready !== 1'b0 || frame_ready !== 1'b1) begin
         errors++; $display("FAIL queue_ready_return: got before=%b after=%b expected 0/1", prev_ready, frame_ready); end
   endtask

   task automatic test_bit_widths();
      int w;
      capture_minute();
      checks++; if (hi_cnt[0][5] != 20) begin errors++; $display("FAIL bit5_width: got %0d expected 20", hi_cnt[0][5]); end
      checks++; if (hi_cnt[0][6] != 10) begin errors++; $display("FAIL bit6_width: got %0d expected 10", hi_cnt[0][6]); end
      checks++; if (idx_bad[0][5] != 0) begin errors++; $display("FAIL bit5_sec_index: got %0d bad cycles expected 0", idx_bad[0][5]); end
      checks++; if (ur_cnt != 0 || strobe_bad != 0) begin
         errors++; $display("FAIL frame_b_flags: got underrun=%0d strobe_bad=%0d expected 0/0", ur_cnt, strobe_bad); end
      for (int s = 0; s < 60; s++) begin
         w = exp_width(frame_b, s);
         checks++;
         if (hi_cnt[0][s] != w || first_lo[0][s] != w) begin
            errors++; $display("FAIL raw_width_s%0d: got high=%0d first_low=%0d expected %0d", s, hi_cnt[0][s], first_lo[0][s], w);
         end
      end
   endtask

   task automatic test_auto_parity();
      logic [58:0] exp_f;
      int w;
      exp_f = '0;
      exp_f[5] = 1'b1; exp_f[20] = 1'b1; exp_f[21] = 1'b1; exp_f[22] = 1'b1;
      exp_f[23] = 1'b1; exp_f[28] = 1'b1;
      checks++; if (hi_cnt[1][0] != 10) begin errors++; $display("FAIL ap_bit0: got %0d expected 10", hi_cnt[1][0]); end
      checks++; if (hi_cnt[1][20] != 20) begin errors++; $display("FAIL ap_bit20: got %0d expected 20", hi_cnt[1][20]); end
      checks++; if (hi_cnt[1][28] != 20) begin errors++; $display("FAIL ap_bit28: got %0d expected 20", hi_cnt[1][28]); end
      checks++; if (hi_cnt[1][35] != 10) begin errors++; $display("FAIL ap_bit35: got %0d expected 10", hi_cnt[1][35]); end
      checks++; if (hi_cnt[1][58] != 10) begin errors++; $display("FAIL ap_bit58: got %0d expected 10", hi_cnt[1][58]); end
      for (int s = 0; s < 60; s++) begin
         w = exp_width(exp_f, s);
         checks++;
         if (hi_cnt[1][s] != w || first_lo[1][s] != w || idx_bad[1][s] != 0) begin
            errors++; $display("FAIL ap_width_s%0d: got high=%0d first_low=%0d idx_bad=%0d expected %0d",
                               s, hi_cnt[1][s], first_lo[1][s], idx_bad[1][s], w);
         end
      end
   endtask

   task automatic test_enable_abort();
      frame_in = 59'd2; frame_valid = 1'b1;
      tick();
      checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL abort_queue: got %b expected 0", frame_ready); end
      frame_valid = 1'b0;
      repeat (1202) tick();
      checks++; if (dcf !== 1'b1 || sec_index !== 6'd12) begin
         errors++; $display("FAIL abort_pre: got dcf=%b sec=%0d expected 1/12", dcf, sec_index); end
      enable = 1'b0;
      tick();
      checks++; if (dcf !== 1'b0 || busy !== 1'b0 || sec_index !== 6'd0) begin
         errors++; $display("FAIL abort_idle: got dcf=%b busy=%b sec=%0d expected 0/0/0", dcf, busy, sec_index); end
      checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL abort_shadow_kept: got %b expected 0", frame_ready); end
      repeat (5) tick();
      checks++; if (dcf !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL abort_stays_idle: got dcf=%b busy=%b expected 0/0", dcf, busy); end
      enable = 1'b1;
      tick();
      checks++; if (dcf !== 1'b1 || minute_strobe !== 1'b1 || sec_index !== 6'd0 || frame_ready !== 1'b1) begin
         errors++; $display("FAIL reenable_restart: got dcf=%b ms=%b sec=%0d ready=%b expected 1/1/0/1",
                            dcf, minute_strobe, sec_index, frame_ready); end
   endtask

   task automatic test_reset_mid();
      int highs;
      repeat (3003) tick();
      checks++; if (dcf !== 1'b1 || sec_index !== 6'd30) begin
         errors++; $display("FAIL midreset_pre: got dcf=%b sec=%0d expected 1/30", dcf, sec_index); end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++; if (dcf !== 1'b0 || sec_index !== 6'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL midreset_out: got dcf=%b sec=%0d busy=%b expected 0/0/0", dcf, sec_index, busy); end
      checks++; if ({second_strobe, minute_strobe, underrun} !== 3'b0 || frame_ready !== 1'b1) begin
         errors++; $display("FAIL midreset_flags: got ss/ms/ur=%b ready=%b expected 000/1",
                            {second_strobe, minute_strobe, underrun}, frame_ready); end
      highs = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (dcf !== 1'b0 || busy !== 1'b0) highs++;
      end
      checks++; if (highs != 0) begin errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", highs); end
      frame_in = '0; frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
      tick();
      checks++; if (minute_strobe !== 1'b1 || dcf !== 1'b1) begin
         errors++; $display("FAIL midreset_resume: got ms=%b dcf=%b expected 1/1", minute_strobe, dcf); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_zero_frame();
      test_queue();
      test_bit_widths();
      test_auto_parity();
      test_enable_abort();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
